writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back datapath: takes the retiring instruction from EX/MEM and waits for the data-memory load response when needed.
- Aligns and sign- or zero-extends load data, then selects the final WriteData.
- Drives the register-file write port (MEM_WB_RegWrite, MEM_WB_WriteAddress, WriteData) consumed by decode.
- Generates decode's ForwardMemToRegData_RS1/RS2 bypass selects and the MemStall that freezes upstream stages during a multi-cycle load.

Parameters:
- WORD_LENGTH, 32, datapath width
- ADDRESS_PORT_WIDTH, 5, register address width
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_RESP before abort (≥1)

Ports:
- CLK  in  1  clock
- Reset_n  in  1  synchronous active-low reset
- EX_MEM_Valid  in  1  EX/MEM slot holds a real instruction
- EX_MEM_RegWrite  in  1  instruction writes rd
- EX_MEM_MemToReg  in  1  instruction is a load
- EX_MEM_RetAddr  in  1  write PC+4 (JAL/JALR)
- EX_MEM_WriteAddress  in  ADDRESS_PORT_WIDTH  rd
- EX_MEM_ALUResult  in  WORD_LENGTH  ALU result / load byte address
- EX_MEM_PC  in  WORD_LENGTH  instruction PC
- EX_MEM_Func3  in  3  load width/sign
- DMemRespValid  in  1  load data valid this cycle
- DMemReadData  in  WORD_LENGTH  word-aligned load data
- IF_ID_RS1, IF_ID_RS2  in  ADDRESS_PORT_WIDTH  decode source registers
- MEM_WB_RegWrite  out  1  register-file write enable (registered)
- MEM_WB_WriteAddress  out  ADDRESS_PORT_WIDTH  write address (registered)
- WriteData  out  WORD_LENGTH  write data (registered)
- MEM_WB_Valid  out  1  one-cycle retire pulse (registered)
- MemStall  out  1  freeze PC/IF/ID/EX/EX_MEM (combinational)
- ForwardMemToRegData_RS1, ForwardMemToRegData_RS2  out  1  bypass WriteData into decode (combinational)
- MisalignedLoad  out  1  one-cycle error pulse (registered)
- LoadTimeout  out  1  sticky error

Behaviour:
- Reset: when Reset_n is low at a CLK edge, every registered output goes to 0, state goes to IDLE, the timeout counter clears, and LoadTimeout clears. Reset is only honoured at CLK edges.
- States: IDLE and WAIT_RESP.
  - IDLE with EX_MEM_Valid=1 and MemToReg=0: commit next edge (1-cycle latency).
  - IDLE with a load and DMemRespValid=1: commit next edge, MemStall=0.
  - IDLE with a load and DMemRespValid=0: MemStall=1 combinationally. Next edge goes to WAIT_RESP; no write that edge (MEM_WB_RegWrite=0, MEM_WB_Valid=0).
  - WAIT_RESP: MemStall=1 unless DMemRespValid=1. On response, commit and return to IDLE. Counter increments each WAIT_RESP cycle.
  - If the counter reaches TIMEOUT_CYCLES without a response: set LoadTimeout, retire with MEM_WB_Valid=1 and RegWrite=0, return to IDLE. MemStall is deasserted in the abort cycle.
- Upstream holds all EX_MEM_* inputs stable while MemStall=1.
- DMemRespValid outside an outstanding load is ignored.
- Commit:
  - MEM_WB_Valid is 1 for one cycle.
  - MEM_WB_WriteAddress = rd.
  - MEM_WB_RegWrite = EX_MEM_RegWrite & (rd != 0) & !misaligned.
  - EX_MEM_Valid=0 in IDLE: a bubble, all write outputs 0.
- WriteData priority:
  1. RetAddr: PC+4, mod 2^WORD_LENGTH.
  2. MemToReg: extended load data, with byte offset = ALUResult[1:0].
     - 000 LB: sign-extend byte[offset].
     - 001 LH: sign-extend half[offset[1]].
     - 010 LW: the full word.
     - 100 LBU: zero-extend byte[offset].
     - 101 LHU: zero-extend half[offset[1]].
     - Other Func3 values: treat as LW.
  3. Otherwise: ALUResult.
- Misaligned load: LH/LHU with offset[0]=1, or LW with offset≠0. Misaligned loads still wait for the response, then commit with RegWrite=0 and MisalignedLoad=1 for one cycle.
- Forwarding: ForwardMemToRegData_RSx = MEM_WB_RegWrite & (MEM_WB_WriteAddress != 0) & (MEM_WB_WriteAddress == IF_ID_RSx). This is a pure function of the registered outputs.
- Reset mid-WAIT_RESP: no write, IDLE; a late response is ignored.

Test Plan:
- Reset_n=0 for 2 cycles with random inputs → all outputs 0, MemStall=0; then an ALU op with rd=5, ALUResult=0x1234 → next cycle RegWrite=1, addr=5, WriteData=0x1234, Valid=1.
- LB at ALUResult=0x103, zero-wait response DMemReadData=0x80FF_7F01 → WriteData=0xFFFF_FF80. Repeat as LBU → 0x0000_0080. LHU at 0x102 → 0x0000_80FF.
- LW, response delayed 3 cycles → MemStall=1 for exactly 3 cycles, no write during the wait, then WriteData=response, RegWrite=1.
- JAL with rd=1, PC=0xFFFF_FFFC → WriteData=0x0000_0000. Same instruction with rd=0 → RegWrite=0, Valid=1, forward selects 0.
- Commit rd=7 with IF_ID_RS1=7, IF_ID_RS2=3 → RS1 forward=1, RS2 forward=0. LW at 0x102 → MisalignedLoad pulse, RegWrite=0.
- Load with no response for 16 cycles → LoadTimeout=1 and stays 1, no write, MemStall drops. Reset_n=0 mid-wait → IDLE; a response the next cycle is ignored.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Bundles the EX/MEM instruction slot, the data-memory load response, the decode
// source registers, and the write-back outputs into one port group.
interface writeback_stage_if #(
    parameter int WORD_LENGTH        = 32,
    parameter int ADDRESS_PORT_WIDTH = 5
);
    logic                          EX_MEM_Valid;
    logic                          EX_MEM_RegWrite;
    logic                          EX_MEM_MemToReg;
    logic                          EX_MEM_RetAddr;
    logic [ADDRESS_PORT_WIDTH-1:0] EX_MEM_WriteAddress;
    logic [WORD_LENGTH-1:0]        EX_MEM_ALUResult;
    logic [WORD_LENGTH-1:0]        EX_MEM_PC;
    logic [2:0]                    EX_MEM_Func3;
    logic                          DMemRespValid;
    logic [WORD_LENGTH-1:0]        DMemReadData;
    logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS1;
    logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS2;

    logic                          MEM_WB_RegWrite;
    logic [ADDRESS_PORT_WIDTH-1:0] MEM_WB_WriteAddress;
    logic [WORD_LENGTH-1:0]        WriteData;
    logic                          MEM_WB_Valid;
    logic                          MemStall;
    logic                          ForwardMemToRegData_RS1;
    logic                          ForwardMemToRegData_RS2;
    logic                          MisalignedLoad;
    logic                          LoadTimeout;

    // The pipeline side that feeds the stage and consumes its results.
    modport master (
        output EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemToReg, EX_MEM_RetAddr,
               EX_MEM_WriteAddress, EX_MEM_ALUResult, EX_MEM_PC, EX_MEM_Func3,
               DMemRespValid, DMemReadData, IF_ID_RS1, IF_ID_RS2,
        input  MEM_WB_RegWrite, MEM_WB_WriteAddress, WriteData, MEM_WB_Valid,
               MemStall, ForwardMemToRegData_RS1, ForwardMemToRegData_RS2,
               MisalignedLoad, LoadTimeout
    );

    // The writeback stage itself.
    modport slave (
        input  EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemToReg, EX_MEM_RetAddr,
               EX_MEM_WriteAddress, EX_MEM_ALUResult, EX_MEM_PC, EX_MEM_Func3,
               DMemRespValid, DMemReadData, IF_ID_RS1, IF_ID_RS2,
        output MEM_WB_RegWrite, MEM_WB_WriteAddress, WriteData, MEM_WB_Valid,
               MemStall, ForwardMemToRegData_RS1, ForwardMemToRegData_RS2,
               MisalignedLoad, LoadTimeout
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath: waits for load responses,
// aligns and extends load data, drives the register-file write port and bypasses.
module writeback_stage #(
    parameter int WORD_LENGTH        = 32,
    parameter int ADDRESS_PORT_WIDTH = 5,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    writeback_stage_if.slave  wb
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, WAIT_RESP} state_t;

    state_t                        state_reg, state_next;
    logic [CNT_W-1:0]              timeout_cnt_reg, timeout_cnt_next;
    logic                          regwrite_reg, regwrite_next;
    logic [ADDRESS_PORT_WIDTH-1:0] write_addr_reg, write_addr_next;
    logic [WORD_LENGTH-1:0]        write_data_reg, write_data_next;
    logic                          valid_reg, valid_next;
    logic                          misaligned_reg, misaligned_next;
    logic                          timeout_reg, timeout_next;

    logic                          commit;
    logic                          abort;
    logic                          stall;

    // Load data alignment: pick the addressed byte/half out of the word.
    logic [7:0]             load_byte [4];
    logic [1:0]             byte_off;
    logic [7:0]             sel_byte;
    logic [15:0]            sel_half;
    logic [WORD_LENGTH-1:0] load_ext;
    logic [WORD_LENGTH-1:0] result_data;
    logic                   misaligned;
    logic                   bad_load;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign load_byte[gi] = wb.DMemReadData[8*gi +: 8];
    end

    assign byte_off = wb.EX_MEM_ALUResult[1:0];
    assign sel_byte = load_byte[byte_off];
    assign sel_half = byte_off[1] ? {load_byte[3], load_byte[2]}
                                  : {load_byte[1], load_byte[0]};

    always_comb begin
        load_ext   = wb.DMemReadData;
        misaligned = (byte_off != 2'b00);
        case (wb.EX_MEM_Func3)
            3'b000: begin
                load_ext   = {{(WORD_LENGTH-8){sel_byte[7]}}, sel_byte};
                misaligned = 1'b0;
            end
            3'b001: begin
                load_ext   = {{(WORD_LENGTH-16){sel_half[15]}}, sel_half};
                misaligned = byte_off[0];
            end
            3'b100: begin
                load_ext   = {{(WORD_LENGTH-8){1'b0}}, sel_byte};
                misaligned = 1'b0;
            end
            3'b101: begin
                load_ext   = {{(WORD_LENGTH-16){1'b0}}, sel_half};
                misaligned = byte_off[0];
            end
            default: ;
        endcase
    end

    assign bad_load    = wb.EX_MEM_MemToReg & misaligned;
    assign result_data = wb.EX_MEM_RetAddr  ? wb.EX_MEM_PC + WORD_LENGTH'(4) :
                         wb.EX_MEM_MemToReg ? load_ext : wb.EX_MEM_ALUResult;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timeout_cnt_next = timeout_cnt_reg;
        commit           = 1'b0;
        abort            = 1'b0;
        stall            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wb.EX_MEM_Valid) begin
                    if (!wb.EX_MEM_MemToReg || wb.DMemRespValid) begin
                        commit = 1'b1;
                    end else begin
                        stall            = 1'b1;
                        state_next       = WAIT_RESP;
                        timeout_cnt_next = '0;
                    end
                end
            end
            WAIT_RESP: begin
                // The last permitted wait cycle aborts instead of stalling again.
                if (wb.DMemRespValid) begin
                    commit           = 1'b1;
                    state_next       = IDLE;
                    timeout_cnt_next = '0;
                end else if (timeout_cnt_reg == CNT_LAST) begin
                    abort            = 1'b1;
                    state_next       = IDLE;
                    timeout_cnt_next = '0;
                end else begin
                    stall            = 1'b1;
                    timeout_cnt_next = timeout_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_next      = commit | abort;
        write_addr_next = (commit | abort) ? wb.EX_MEM_WriteAddress : '0;
        regwrite_next   = commit & wb.EX_MEM_RegWrite &
                          (wb.EX_MEM_WriteAddress != '0) & ~bad_load;
        write_data_next = commit ? result_data : '0;
        misaligned_next = commit & bad_load;
        timeout_next    = timeout_reg | abort;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            regwrite_reg   <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            valid_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            regwrite_reg   <= regwrite_next;
            write_addr_reg <= write_addr_next;
            write_data_reg <= write_data_next;
            valid_reg      <= valid_next;
            misaligned_reg <= misaligned_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Upstream must never see a freeze while reset is being applied.
    assign wb.MemStall            = Reset_n & stall;
    assign wb.MEM_WB_RegWrite     = regwrite_reg;
    assign wb.MEM_WB_WriteAddress = write_addr_reg;
    assign wb.WriteData           = write_data_reg;
    assign wb.MEM_WB_Valid        = valid_reg;
    assign wb.MisalignedLoad      = misaligned_reg;
    assign wb.LoadTimeout         = timeout_reg;

    assign wb.ForwardMemToRegData_RS1 = regwrite_reg & (write_addr_reg != '0) &
                                        (write_addr_reg == wb.IF_ID_RS1);
    assign wb.ForwardMemToRegData_RS2 = regwrite_reg & (write_addr_reg != '0) &
                                        (write_addr_reg == wb.IF_ID_RS2);
endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized instruction stream for writeback_stage, checked against
// a transaction-level model of commit timing, load extension and forwarding.
module tb_writeback_stage;
    localparam int WL = 32;
    localparam int AW = 5;
    localparam int T  = 16;

    logic CLK     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 CLK = ~CLK;

    writeback_stage_if #(.WORD_LENGTH(WL), .ADDRESS_PORT_WIDTH(AW)) wb ();

    writeback_stage #(
        .WORD_LENGTH(WL),
        .ADDRESS_PORT_WIDTH(AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK),
        .Reset_n(Reset_n),
        .wb(wb)
    );

    int checks   = 0;
    int failures = 0;
    bit timed_out_model = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_data(input bit ra, input bit m2r,
                                               input logic [31:0] alu, input logic [31:0] pc,
                                               input logic [2:0] f3, input logic [31:0] rdata);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        if (ra) return pc + 32'd4;
        if (!m2r) return alu;
        off = alu % 4;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] alu);
        int unsigned off;
        off = alu % 4;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        return off != 0;
    endfunction

    // delay: cycle index (0 = issue cycle) at which the response arrives; -1 = never
    task automatic run_instr(input bit v, input bit rw, input bit m2r, input bit ra,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc,
                             input logic [2:0] f3, input int delay, input logic [31:0] rdata,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        bit is_load, tmo, e_rw, e_mis, e_valid;
        int last;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        is_load = v && m2r;
        tmo     = is_load && (delay < 0 || delay > T);
        last    = !is_load ? 0 : (tmo ? T : delay);

        wb.EX_MEM_Valid        = v;
        wb.EX_MEM_RegWrite     = rw;
        wb.EX_MEM_MemToReg     = m2r;
        wb.EX_MEM_RetAddr      = ra;
        wb.EX_MEM_WriteAddress = rd;
        wb.EX_MEM_ALUResult    = alu;
        wb.EX_MEM_PC           = pc;
        wb.EX_MEM_Func3        = f3;

        for (int c = 0; c <= last; c++) begin
            wb.DMemRespValid = is_load ? (c == delay) : 1'($urandom_range(0, 1));
            wb.DMemReadData  = (is_load && c == delay) ? rdata : $urandom;
            @(negedge CLK);
            check_eq("mem_stall", wb.MemStall, (c < last));
            @(posedge CLK);
            #1;
            if (c < last) begin
                check_eq("wait_valid", wb.MEM_WB_Valid, 0);
                check_eq("wait_regwrite", wb.MEM_WB_RegWrite, 0);
            end
        end
        wb.DMemRespValid = 1'b0;

        e_valid = v;
        e_addr  = v ? rd : 5'd0;
        e_mis   = 1'b0;
        e_rw    = 1'b0;
        e_data  = 32'd0;
        if (tmo) begin
            timed_out_model = 1'b1;
        end else if (v) begin
            e_mis  = is_load && model_misaligned(f3, alu);
            e_rw   = rw && (rd != 0) && !e_mis;
            e_data = model_data(ra, m2r, alu, pc, f3, rdata);
        end
        check_eq("valid", wb.MEM_WB_Valid, e_valid);
        check_eq("regwrite", wb.MEM_WB_RegWrite, e_rw);
        check_eq("write_addr", wb.MEM_WB_WriteAddress, e_addr);
        if (!tmo) check_eq("write_data", wb.WriteData, e_data);
        check_eq("misaligned", wb.MisalignedLoad, e_mis);
        check_eq("load_timeout", wb.LoadTimeout, timed_out_model);

        wb.IF_ID_RS1 = rs1;
        wb.IF_ID_RS2 = rs2;
        #1;
        check_eq("fwd_rs1", wb.ForwardMemToRegData_RS1, e_rw && e_addr != 0 && e_addr == rs1);
        check_eq("fwd_rs2", wb.ForwardMemToRegData_RS2, e_rw && e_addr != 0 && e_addr == rs2);
        $display("txn v=%0b ld=%0b ra=%0b rd=%0d f3=%0d alu=0x%08h delay=%0d data=0x%08h",
                 v, m2r, ra, rd, f3, alu, delay, wb.WriteData);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, wb.MEM_WB_Valid, 0);
        check_eq({tag, "_regwrite"}, wb.MEM_WB_RegWrite, 0);
        check_eq({tag, "_addr"}, wb.MEM_WB_WriteAddress, 0);
        check_eq({tag, "_data"}, wb.WriteData, 0);
        check_eq({tag, "_misaligned"}, wb.MisalignedLoad, 0);
        check_eq({tag, "_timeout"}, wb.LoadTimeout, 0);
        check_eq({tag, "_stall"}, wb.MemStall, 0);
        check_eq({tag, "_fwd1"}, wb.ForwardMemToRegData_RS1, 0);
        check_eq({tag, "_fwd2"}, wb.ForwardMemToRegData_RS2, 0);
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2;
        f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;

        // Reset with random inputs on the bus
        Reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wb.EX_MEM_Valid        = 1'b1;
            wb.EX_MEM_RegWrite     = 1'($urandom);
            wb.EX_MEM_MemToReg     = 1'b1;
            wb.EX_MEM_RetAddr      = 1'($urandom);
            wb.EX_MEM_WriteAddress = 5'($urandom);
            wb.EX_MEM_ALUResult    = $urandom;
            wb.EX_MEM_PC           = $urandom;
            wb.EX_MEM_Func3        = 3'($urandom);
            wb.DMemRespValid       = 1'b0;
            wb.DMemReadData        = $urandom;
            wb.IF_ID_RS1           = 5'($urandom);
            wb.IF_ID_RS2           = 5'($urandom);
            @(posedge CLK);
            #1;
            check_all_zero("reset");
        end
        Reset_n = 1'b1;

        run_instr(1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 3'd0, 0, 32'h0, 5'd5, 5'd6);
        run_instr(1, 1, 1, 0, 5'd3, 32'h103, 32'h0, 3'd0, 0, 32'h80FF_7F01, 5'd1, 5'd2);
        run_instr(1, 1, 1, 0, 5'd3, 32'h103, 32'h0, 3'd4, 0, 32'h80FF_7F01, 5'd1, 5'd3);
        run_instr(1, 1, 1, 0, 5'd4, 32'h102, 32'h0, 3'd5, 0, 32'h80FF_7F01, 5'd4, 5'd4);
        run_instr(1, 1, 1, 0, 5'd9, 32'h200, 32'h0, 3'd2, 3, 32'hDEAD_BEEF, 5'd9, 5'd0);
        run_instr(1, 1, 0, 1, 5'd1, 32'h55, 32'hFFFF_FFFC, 3'd0, 0, 32'h0, 5'd1, 5'd2);
        run_instr(1, 1, 0, 1, 5'd0, 32'h55, 32'hFFFF_FFFC, 3'd0, 0, 32'h0, 5'd0, 5'd0);
        run_instr(1, 1, 0, 0, 5'd7, 32'hABCD, 32'h40, 3'd0, 0, 32'h0, 5'd7, 5'd3);
        run_instr(1, 1, 1, 0, 5'd8, 32'h102, 32'h0, 3'd2, 1, 32'h1111_2222, 5'd8, 5'd8);
        run_instr(0, 1, 1, 0, 5'd8, 32'h102, 32'h0, 3'd2, 0, 32'h0, 5'd8, 5'd8);
        run_instr(1, 1, 1, 0, 5'd10, 32'h300, 32'h0, 3'd2, -1, 32'h0, 5'd10, 5'd0);
        run_instr(1, 1, 1, 0, 5'd11, 32'h304, 32'h0, 3'd2, T, 32'h7777_0000, 5'd11, 5'd0);

        // Reset while a load is outstanding; a late response must be ignored
        wb.EX_MEM_Valid    = 1'b1;
        wb.EX_MEM_MemToReg = 1'b1;
        wb.EX_MEM_RegWrite = 1'b1;
        wb.EX_MEM_RetAddr  = 1'b0;
        wb.DMemRespValid   = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        Reset_n = 1'b0;
        @(negedge CLK);
        check_eq("rst_wait_stall", wb.MemStall, 0);
        @(posedge CLK);
        #1;
        check_all_zero("rst_wait");
        timed_out_model = 1'b0;
        Reset_n = 1'b1;
        wb.EX_MEM_Valid  = 1'b0;
        wb.DMemRespValid = 1'b1;
        @(negedge CLK);
        check_eq("late_resp_stall", wb.MemStall, 0);
        @(posedge CLK);
        #1;
        check_eq("late_resp_valid", wb.MEM_WB_Valid, 0);
        check_eq("late_resp_regwrite", wb.MEM_WB_RegWrite, 0);
        wb.DMemRespValid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            bit v, m2r, ra;
            logic [4:0] rd, rs1;
            int delay, r;
            v   = ($urandom_range(0, 9) != 0);
            m2r = 1'($urandom);
            ra  = !m2r && ($urandom_range(0, 9) == 0);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rs1 = $urandom_range(0, 1) ? rd : 5'($urandom);
            r   = int'($urandom_range(0, 39));
            delay = (r == 0) ? -1 : (r == 1) ? T : int'($urandom_range(0, 4));
            run_instr(v, 1'($urandom), m2r, ra, rd, $urandom, $urandom,
                      f3_tab[$urandom_range(0, 4)], delay, $urandom, rs1, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
